// File: rtl/ps2_rx_framer_pkg.sv
// Shared definitions for the PS/2 receive framer: state encoding, frame geometry
// and the capture register field map.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ps2_rx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int FRAME_LEN = 11;
    localparam int CNT_W     = 4;

    // Capture register is shifted left, so the first bit on the wire (start)
    // ends up in the MSB and the stop bit in bit 0.
    localparam int CAP_START = 10;
    localparam int CAP_D_MSB = 9;   // first data bit received (byte bit 0)
    localparam int CAP_D_LSB = 2;   // last data bit received (byte bit 7)
    localparam int CAP_PAR   = 1;
    localparam int CAP_STOP  = 0;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_framer_if.sv
// Output bundle of the PS/2 receive framer: bit strobe, byte result and status.
// Latency: n/a (wires only). Backpressure: none; every signal is a strobe or level.
// master drives the bundle (framer), slave observes it (shift register / decode).
interface ps2_rx_framer_if;
    logic       o_bit_en;   // one-cycle pulse per sampled frame bit
    logic       o_bit_dat;  // bit sampled with o_bit_en
    logic [7:0] o_data;     // last good byte, bit 0 = first data bit
    logic       o_valid;    // one-cycle pulse when o_data updates
    logic       o_err;      // one-cycle pulse on parity/stop/timeout error
    logic       o_busy;     // frame in progress

    modport master (
        output o_bit_en, o_bit_dat, o_data, o_valid, o_err, o_busy
    );

    modport slave (
        input  o_bit_en, o_bit_dat, o_data, o_valid, o_err, o_busy
    );
endinterface

// File: rtl/ps2_pin_filter.sv
// PS/2 pin conditioning: synchronizers, level filter on the clock, falling-edge pulse.
// Latency: clock edge pulse ~SYNC_STAGES+FILTER_LEN+1 cycles after the pin falls.
// Backpressure: none; o_clk_fall is a free-running one-cycle pulse.
// Ports: clk, i_sclr_n (sync, active-low), i_ps2_clk/i_ps2_dat raw pins,
//        o_clk_fall edge pulse, o_dat_sync synchronized data pin.
module ps2_pin_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic i_sclr_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_fall,
    output logic o_dat_sync
);

    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [FCW-1:0]         flt_cnt;
    logic                   clk_filt;
    logic                   clk_filt_d;

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            flt_cnt    <= '0;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            dat_sync   <= {dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            clk_filt_d <= clk_filt;
            // Count consecutive samples that disagree with the filtered level;
            // any agreeing sample restarts the run, so short glitches vanish.
            if (clk_sync[SYNC_STAGES-1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[SYNC_STAGES-1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign o_clk_fall = clk_filt_d & ~clk_filt;
    assign o_dat_sync = dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host framer: collects 11-bit characters, checks parity/stop, emits bytes.
// Latency: o_bit_en at E+1 of each clock edge E; o_valid/o_err at E+2 of the stop edge.
// Backpressure: none; results are one-cycle strobes that the consumer must take.
// Ports: clk, i_sclr_n (sync, active-low), i_ps2_clk/i_ps2_dat raw pins,
//        rx (master) carrying o_bit_en, o_bit_dat, o_data, o_valid, o_err, o_busy.
module ps2_rx_framer
    import ps2_rx_framer_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              i_sclr_n,
    input  logic              i_ps2_clk,
    input  logic              i_ps2_dat,
    ps2_rx_framer_if.master   rx
);

    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_fall;
    logic dat_s;

    ps2_pin_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_pin_filter (
        .clk        (clk),
        .i_sclr_n   (i_sclr_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_dat  (i_ps2_dat),
        .o_clk_fall (clk_fall),
        .o_dat_sync (dat_s)
    );

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]   cap_q, cap_d;
    logic [TOW-1:0]         to_q, to_d;
    logic                   bit_en_q, bit_en_d;
    logic                   bit_dat_q, bit_dat_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   frame_ok;

    // Odd parity over data+parity, stop high, start low.
    assign frame_ok = ~cap_q[CAP_START] & cap_q[CAP_STOP] & (^cap_q[CAP_D_MSB:CAP_PAR]);

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cap_q     <= '0;
            to_q      <= '0;
            bit_en_q  <= 1'b0;
            bit_dat_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            to_q      <= to_d;
            bit_en_q  <= bit_en_d;
            bit_dat_q <= bit_dat_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        to_d      = to_q;
        bit_en_d  = 1'b0;
        bit_dat_d = bit_dat_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                to_d = '0;
                // Only a low data bit on the edge is a start bit.
                if (clk_fall && !dat_s) begin
                    state_d   = ST_RECV;
                    cnt_d     = CNT_W'(1);
                    cap_d     = {cap_q[FRAME_LEN-2:0], dat_s};
                    bit_en_d  = 1'b1;
                    bit_dat_d = dat_s;
                end
            end
            ST_RECV: begin
                to_d = to_q + 1'b1;
                // Timeout has priority over an edge arriving in the same cycle.
                if (to_q == TOW'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    to_d    = '0;
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    cap_d     = {cap_q[FRAME_LEN-2:0], dat_s};
                    cnt_d     = cnt_q + 1'b1;
                    to_d      = '0;
                    bit_en_d  = 1'b1;
                    bit_dat_d = dat_s;
                    if (cnt_q + 1'b1 == CNT_W'(FRAME_LEN)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                if (frame_ok) begin
                    data_d  = bit_reverse8(cap_q[CAP_D_MSB:CAP_D_LSB]);
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx.o_bit_en  = bit_en_q;
    assign rx.o_bit_dat = bit_dat_q;
    assign rx.o_data    = data_q;
    assign rx.o_valid   = valid_q;
    assign rx.o_err     = err_q;
    assign rx.o_busy    = (state_q != ST_IDLE);

endmodule
